// File: rtl/data_memory_responder_if.sv
// Data-memory bus bundle: core access port, comms 4-phase req/ack port and status.
// master = requesters (core + comms processor), slave = data_memory_responder.
interface data_memory_responder_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address_rw;
  logic                  memory_write_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  core_hold;
  logic                  comms_req;
  logic                  comms_we;
  logic [ADDR_WIDTH-1:0] comms_addr;
  logic [DATA_WIDTH-1:0] comms_wdata;
  logic                  comms_ack;
  logic [DATA_WIDTH-1:0] comms_rdata;
  logic                  busy;

  modport master (
    output address_rw, memory_write_enable, data_in,
    output comms_req, comms_we, comms_addr, comms_wdata,
    input  data_out, core_hold, comms_ack, comms_rdata, busy
  );

  modport slave (
    input  address_rw, memory_write_enable, data_in,
    input  comms_req, comms_we, comms_addr, comms_wdata,
    output data_out, core_hold, comms_ack, comms_rdata, busy
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: single-write-port RAM shared by the core and a comms requester.
// Optional feature macro MEM_CLEAR_EN: zero the whole RAM after every reset release.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int STALL_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  data_memory_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

`ifdef MEM_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r;
  state_t                state_s;
  logic                  lat_we_r;
  logic [ADDR_WIDTH-1:0] lat_addr_r;
  logic [DATA_WIDTH-1:0] lat_wdata_r;
  logic [CNT_W-1:0]      defer_cnt_r;
  logic                  comms_ack_r;
  logic [DATA_WIDTH-1:0] comms_rdata_r;
  logic                  core_hold_s;
  logic                  comms_wr_s;
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

`ifdef MEM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_ptr_r;
  logic                  busy_r;
`endif

  // Next-state, core stall and comms-write decision.
  always_comb begin
    state_s     = state_r;
    core_hold_s = 1'b0;
    comms_wr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.comms_req) begin
          state_s = ST_SERVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (!lat_we_r) begin
          state_s = ST_ACK;
        end else if (defer_cnt_r == LIMIT_C) begin
          // Starvation bound reached: steal the port and drop this cycle's core write.
          core_hold_s = 1'b1;
          comms_wr_s  = 1'b1;
          state_s     = ST_ACK;
        end else if (!bus.memory_write_enable) begin
          comms_wr_s = 1'b1;
          state_s    = ST_ACK;
        end else begin
          state_s = ST_SERVE;
        end
      end
      ST_ACK: begin
        if (!bus.comms_req) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACK;
        end
      end
      ST_CLEAR: begin
`ifdef MEM_CLEAR_EN
        core_hold_s = 1'b1;
        if (clr_ptr_r == ADDR_WIDTH'(DEPTH - 1)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_CLEAR;
        end
`else
        state_s = ST_IDLE;
`endif
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Single write port arbitration: clear sweep, then comms write, then core write.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = bus.address_rw;
    mem_wdata_s = bus.data_in;
    if (state_r == ST_CLEAR) begin
`ifdef MEM_CLEAR_EN
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_ptr_r;
      mem_wdata_s = {DATA_WIDTH{1'b0}};
`else
      mem_we_s    = 1'b0;
`endif
    end else if (comms_wr_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = lat_addr_r;
      mem_wdata_s = lat_wdata_r;
    end else begin
      mem_we_s    = bus.memory_write_enable & ~core_hold_s;
    end
  end

  // RAM array; never reset, and no writes land while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we_s && rst) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // FSM state, comms latch, deferral counter and registered comms outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= RESET_STATE;
      lat_we_r      <= 1'b0;
      lat_addr_r    <= {ADDR_WIDTH{1'b0}};
      lat_wdata_r   <= {DATA_WIDTH{1'b0}};
      defer_cnt_r   <= {CNT_W{1'b0}};
      comms_ack_r   <= 1'b0;
      comms_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      comms_ack_r <= (state_s == ST_ACK);
      if (state_r == ST_IDLE && bus.comms_req) begin
        lat_we_r    <= bus.comms_we;
        lat_addr_r  <= bus.comms_addr;
        lat_wdata_r <= bus.comms_wdata;
        defer_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_SERVE && lat_we_r && !comms_wr_s
                   && defer_cnt_r != LIMIT_C) begin
        defer_cnt_r <= defer_cnt_r + CNT_W'(1);
      end else begin
        defer_cnt_r <= defer_cnt_r;
      end
      // Read samples the pre-edge contents, so a same-edge core write is not seen.
      if (state_r == ST_SERVE && !lat_we_r) begin
        comms_rdata_r <= mem_r[lat_addr_r];
      end else begin
        comms_rdata_r <= comms_rdata_r;
      end
    end
  end

`ifdef MEM_CLEAR_EN
  // Clear sweep pointer and busy flag; reset restarts the sweep from word 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_ptr_r <= {ADDR_WIDTH{1'b0}};
      busy_r    <= 1'b1;
    end else begin
      busy_r <= (state_s == ST_CLEAR);
      if (state_r == ST_CLEAR) begin
        clr_ptr_r <= clr_ptr_r + ADDR_WIDTH'(1);
      end else begin
        clr_ptr_r <= {ADDR_WIDTH{1'b0}};
      end
    end
  end

  assign bus.busy = busy_r;
`else
  assign bus.busy = 1'b0;
`endif

  assign bus.data_out    = mem_r[bus.address_rw];
  assign bus.core_hold   = core_hold_s;
  assign bus.comms_ack   = comms_ack_r;
  assign bus.comms_rdata = comms_rdata_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: core write/read table plus comms handshake sequences.
module tb_data_memory_responder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [15:0] last_core;

  data_memory_responder_if #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) bus ();

  data_memory_responder #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(16),
    .STALL_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.address_rw = 5'd0;
    bus.memory_write_enable = 1'b0;
    bus.data_in = 16'h0000;
    bus.comms_req = 1'b0;
    bus.comms_we = 1'b0;
    bus.comms_addr = 5'd0;
    bus.comms_wdata = 16'h0000;

    vecs[0] = '{1'b1, 5'd5,  16'hBEEF, 16'hBEEF};
    vecs[1] = '{1'b1, 5'd31, 16'hFFFF, 16'hFFFF};
    vecs[2] = '{1'b1, 5'd0,  16'h0001, 16'h0001};
    vecs[3] = '{1'b0, 5'd5,  16'h0000, 16'hBEEF};
    vecs[4] = '{1'b1, 5'd10, 16'h1357, 16'h1357};
    vecs[5] = '{1'b0, 5'd31, 16'h0000, 16'hFFFF};
    vecs[6] = '{1'b0, 5'd0,  16'h0000, 16'h0001};
    vecs[7] = '{1'b1, 5'd7,  16'h0001, 16'h0001};
    vecs[8] = '{1'b1, 5'd9,  16'h0042, 16'h0042};
    vecs[9] = '{1'b0, 5'd10, 16'hFFFF, 16'h1357};

    // Reset state
    #2;
    check("rst_ack", bus.comms_ack, 32'd0);
    check("rst_rdata", bus.comms_rdata, 32'd0);
    check("rst_hold", bus.core_hold, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Core write/read table
    for (int i = 0; i < 10; i++) begin
      bus.address_rw = vecs[i].addr;
      bus.memory_write_enable = vecs[i].we;
      bus.data_in = vecs[i].wdata;
      tick();
      bus.memory_write_enable = 1'b0;
      #1;
      check($sformatf("vec%0d_dout", i), bus.data_out, {16'd0, vecs[i].exp_dout});
      check($sformatf("vec%0d_hold", i), bus.core_hold, 32'd0);
    end

    // Uncontended comms read of addr 5; later address changes must be ignored
    bus.comms_req = 1'b1;
    bus.comms_we = 1'b0;
    bus.comms_addr = 5'd5;
    tick();
    bus.comms_addr = 5'd0;
    check("rd_ack_n", bus.comms_ack, 32'd0);
    tick();
    check("rd_ack_n1", bus.comms_ack, 32'd1);
    check("rd_rdata", bus.comms_rdata, 32'h0000BEEF);
    tick();
    check("rd_ack_hold", bus.comms_ack, 32'd1);
    bus.comms_req = 1'b0;
    tick();
    check("rd_ack_drop", bus.comms_ack, 32'd0);
    check("rd_rdata_keep", bus.comms_rdata, 32'h0000BEEF);

    // No write bypass: old data visible until the edge
    bus.address_rw = 5'd5;
    bus.data_in = 16'h7777;
    bus.memory_write_enable = 1'b1;
    #1;
    check("nobypass_pre", bus.data_out, 32'h0000BEEF);
    tick();
    bus.memory_write_enable = 1'b0;
    check("nobypass_post", bus.data_out, 32'h00007777);

    // Uncontended comms write to addr 0
    bus.comms_req = 1'b1;
    bus.comms_we = 1'b1;
    bus.comms_addr = 5'd0;
    bus.comms_wdata = 16'hC0DE;
    tick();
    bus.comms_wdata = 16'h0BAD;
    check("wr_ack_n", bus.comms_ack, 32'd0);
    tick();
    check("wr_ack_n1", bus.comms_ack, 32'd1);
    bus.address_rw = 5'd0;
    #1;
    check("wr_mem0", bus.data_out, 32'h0000C0DE);
    bus.comms_req = 1'b0;
    tick();
    check("wr_ack_drop", bus.comms_ack, 32'd0);

    // Starvation: core writes every cycle, comms write addr 3 forced after 8 deferrals
    bus.comms_req = 1'b1;
    bus.comms_we = 1'b1;
    bus.comms_addr = 5'd3;
    bus.comms_wdata = 16'h1234;
    bus.memory_write_enable = 1'b1;
    bus.address_rw = 5'd20;
    bus.data_in = 16'h0100;
    tick();
    check("starve_hold0", bus.core_hold, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      bus.data_in = 16'h0100 + 16'(k);
      last_core = bus.data_in;
      tick();
      check($sformatf("starve_hold%0d", k), bus.core_hold, 32'd0);
      check($sformatf("starve_ack%0d", k), bus.comms_ack, 32'd0);
    end
    bus.data_in = 16'h0108;
    last_core = 16'h0108;
    tick();
    check("starve_hold_on", bus.core_hold, 32'd1);
    check("starve_ack_pre", bus.comms_ack, 32'd0);
    bus.data_in = 16'hDEAD;
    tick();
    check("starve_hold_off", bus.core_hold, 32'd0);
    check("starve_ack", bus.comms_ack, 32'd1);
    bus.memory_write_enable = 1'b0;
    bus.address_rw = 5'd3;
    #1;
    check("starve_mem3", bus.data_out, 32'h00001234);
    bus.address_rw = 5'd20;
    #1;
    check("starve_dropped", bus.data_out, {16'd0, last_core});
    bus.comms_req = 1'b0;
    tick();
    check("starve_ack_drop", bus.comms_ack, 32'd0);

    // Same-address race: comms read sees old data, core write lands after
    bus.comms_req = 1'b1;
    bus.comms_we = 1'b0;
    bus.comms_addr = 5'd7;
    tick();
    bus.memory_write_enable = 1'b1;
    bus.address_rw = 5'd7;
    bus.data_in = 16'hAAAA;
    tick();
    bus.memory_write_enable = 1'b0;
    check("race_ack", bus.comms_ack, 32'd1);
    check("race_rdata", bus.comms_rdata, 32'h00000001);
    check("race_dout", bus.data_out, 32'h0000AAAA);
    bus.comms_req = 1'b0;
    tick();
    check("race_ack_drop", bus.comms_ack, 32'd0);

    // Abort: reset while a deferred write to addr 9 is in SERVE
    bus.comms_req = 1'b1;
    bus.comms_we = 1'b1;
    bus.comms_addr = 5'd9;
    bus.comms_wdata = 16'h9999;
    bus.memory_write_enable = 1'b1;
    bus.address_rw = 5'd12;
    bus.data_in = 16'h5A5A;
    tick();
    check("abort_serve_hold", bus.core_hold, 32'd0);
    rst = 1'b0;
    bus.memory_write_enable = 1'b0;
    bus.comms_we = 1'b0;
    #1;
    check("abort_ack", bus.comms_ack, 32'd0);
    check("abort_rdata", bus.comms_rdata, 32'd0);
    check("abort_hold", bus.core_hold, 32'd0);
    check("abort_busy", bus.busy, 32'd0);
    tick();
    rst = 1'b1;
    bus.address_rw = 5'd9;
    #1;
    check("abort_mem9", bus.data_out, 32'h00000042);
    // req still high after release: treated as a fresh read of addr 9
    tick();
    check("reissue_ack_n", bus.comms_ack, 32'd0);
    tick();
    check("reissue_ack", bus.comms_ack, 32'd1);
    check("reissue_rdata", bus.comms_rdata, 32'h00000042);
    bus.comms_req = 1'b0;
    tick();
    check("reissue_ack_drop", bus.comms_ack, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
